// File: rtl/prm_chk_pkg.sv
// prm_chk_pkg: shared FSM encoding, default parameters and count widths for prm_edge_chk_engine
//   no ports; optional hit counters (macro PRM_CHK_HITCNT_EN) use HIT_W
package prm_chk_pkg;
    localparam int DEF_IN_W      = 15;
    localparam int DEF_NUM_CH    = 4;
    localparam int DEF_NUM_TERMS = 64;
    localparam int CNT_W         = 16;
    localparam int HIT_W         = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_e;
    localparam logic [1:0] ST_IDLE  = S_IDLE;
    localparam logic [1:0] ST_ACCUM = S_ACCUM;
    localparam logic [1:0] ST_DRAIN = S_DRAIN;
    localparam logic [1:0] ST_OUT   = S_OUT;
endpackage

// File: rtl/prm_edge_chk_engine_if.sv
// prm_edge_chk_engine_if: sample-in / result-out handshake bundle
//   s_valid/s_ready/s_data/s_last : sample stream into the engine
//   m_valid/m_ready/m_mask/m_count: per-path result out of the engine
//   m_hits                        : per-channel hit counts (only with PRM_CHK_HITCNT_EN)
//   master = stimulus/sink side, slave = engine side
interface prm_edge_chk_engine_if
    import prm_chk_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int NUM_CH = DEF_NUM_CH
);
    logic              s_valid;
    logic              s_ready;
    logic [IN_W-1:0]   s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [NUM_CH-1:0] m_mask;
    logic [CNT_W-1:0]  m_count;
`ifdef PRM_CHK_HITCNT_EN
    logic [NUM_CH*HIT_W-1:0] m_hits;
    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_mask, m_count, m_hits
    );
    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_mask, m_count, m_hits
    );
`else
    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_mask, m_count
    );
    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_mask, m_count
    );
`endif
endinterface

// File: rtl/prm_edge_chk_engine_term_match.sv
// prm_term_match: OR-reduced match of one channel's product terms against a sample
//   data : sample code
//   care : per-term care mask (1 = bit participates)
//   val  : per-term required value on cared bits
//   en   : per-term enable
//   hit  : 1 when any enabled term matches
module prm_term_match #(
    parameter int IN_W      = 15,
    parameter int NUM_TERMS = 64
)(
    input  logic [IN_W-1:0]                 data,
    input  logic [NUM_TERMS-1:0][IN_W-1:0]  care,
    input  logic [NUM_TERMS-1:0][IN_W-1:0]  val,
    input  logic [NUM_TERMS-1:0]            en,
    output logic                            hit
);
    logic [NUM_TERMS-1:0] match;
    always_comb begin
        match = '0;
        for (int t = 0; t < NUM_TERMS; t++)
            match[t] = en[t] & ~|((data ^ val[t]) & care[t]);
    end
    assign hit = |match;
endmodule

// File: rtl/prm_edge_chk_engine.sv
// prm_edge_chk_engine: per-path sticky OR of programmable product-term hits across NUM_CH channels
//   clk, rst        : clock, synchronous active-high reset
//   cfg_we/ch/term  : term write strobe and address
//   cfg_care/val/en : term contents
//   cfg_err         : one-cycle pulse when a write arrives while busy
//   busy            : FSM not in IDLE
//   bus (slave)     : sample stream in, path result out
//   macro PRM_CHK_HITCNT_EN adds per-channel saturating hit counters on bus.m_hits
module prm_edge_chk_engine
    import prm_chk_pkg::*;
#(
    parameter int IN_W      = DEF_IN_W,
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int NUM_TERMS = DEF_NUM_TERMS
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_CH)-1:0]    cfg_ch,
    input  logic [$clog2(NUM_TERMS)-1:0] cfg_term,
    input  logic [IN_W-1:0]              cfg_care,
    input  logic [IN_W-1:0]              cfg_val,
    input  logic                         cfg_en,
    output logic                         cfg_err,
    output logic                         busy,
    prm_edge_chk_engine_if.slave         bus
);
    logic [1:0]                                  state_q, state_d;
    logic [NUM_CH-1:0][NUM_TERMS-1:0]            en_q, en_d;
    logic [NUM_CH-1:0][NUM_TERMS-1:0][IN_W-1:0]  care_q, care_d, val_q, val_d;
    logic [NUM_CH-1:0]                           hit, hit_q, hit_d, acc_q, acc_d;
    logic                                        v1_q, v1_d;
    logic [CNT_W-1:0]                            cnt_q, cnt_d;
    logic                                        cfg_err_q, cfg_err_d;
    logic                                        s_ready, m_valid, accept, wr, clr;

    assign busy        = state_q != ST_IDLE;
    assign s_ready     = state_q == ST_IDLE || state_q == ST_ACCUM;
    assign m_valid     = state_q == ST_OUT;
    assign accept      = bus.s_valid & s_ready;
    assign wr          = cfg_we & ~busy;
    assign clr         = m_valid & bus.m_ready;
    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid;
    assign bus.m_mask  = acc_q;
    assign bus.m_count = cnt_q;
    assign cfg_err     = cfg_err_q;

    // Hits are computed from the table before any same-cycle write lands
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        prm_term_match #(.IN_W(IN_W), .NUM_TERMS(NUM_TERMS)) u_match (
            .data (bus.s_data),
            .care (care_q[c]),
            .val  (val_q[c]),
            .en   (en_q[c]),
            .hit  (hit[c])
        );
    end

    // DRAIN exists so the last sample's stage-2 OR completes before OUT
    always_comb begin
        state_d   = (state_q == ST_IDLE && accept) ? (bus.s_last ? ST_DRAIN : ST_ACCUM)
                  : (state_q == ST_ACCUM && accept && bus.s_last) ? ST_DRAIN
                  : (state_q == ST_DRAIN) ? ST_OUT
                  : clr ? ST_IDLE : state_q;
        hit_d     = accept ? hit : hit_q;
        v1_d      = accept;
        acc_d     = clr ? '0 : v1_q ? acc_q | hit_q : acc_q;
        cnt_d     = clr ? '0 : (v1_q && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
        cfg_err_d = cfg_we & busy;
        en_d      = en_q;
        care_d    = care_q;
        val_d     = val_q;
        if (wr) begin
            en_d[cfg_ch][cfg_term]   = cfg_en;
            care_d[cfg_ch][cfg_term] = cfg_care;
            val_d[cfg_ch][cfg_term]  = cfg_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            en_q      <= '0;
            hit_q     <= '0;
            v1_q      <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            hit_q     <= hit_d;
            v1_q      <= v1_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Term contents are qualified by en, so they need no reset
    always_ff @(posedge clk) begin
        care_q <= care_d;
        val_q  <= val_d;
    end

`ifdef PRM_CHK_HITCNT_EN
    logic [NUM_CH-1:0][HIT_W-1:0] hits_q, hits_d;
    always_comb begin
        hits_d = hits_q;
        for (int i = 0; i < NUM_CH; i++)
            hits_d[i] = clr ? '0 : (v1_q && hit_q[i] && hits_q[i] != '1) ? hits_q[i] + 1'b1 : hits_q[i];
    end
    always_ff @(posedge clk) begin
        if (rst) hits_q <= '0;
        else     hits_q <= hits_d;
    end
    assign bus.m_hits = hits_q;
`endif
endmodule

// File: tb/tb_prm_edge_chk_engine.sv
// tb_prm_edge_chk_engine: directed self-checking bench for prm_edge_chk_engine
//   drives the bus interface and cfg ports; PRM_CHK_HITCNT_EN also checks m_hits
module tb_prm_edge_chk_engine;
    logic        clk, rst;
    logic        cfg_we, cfg_en, cfg_err, busy;
    logic [1:0]  cfg_ch;
    logic [5:0]  cfg_term;
    logic [14:0] cfg_care, cfg_val;
    int          checks, errors;

    prm_edge_chk_engine_if #(.IN_W(15), .NUM_CH(4)) bus ();

    prm_edge_chk_engine #(.IN_W(15), .NUM_CH(4), .NUM_TERMS(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_term (cfg_term),
        .cfg_care (cfg_care),
        .cfg_val  (cfg_val),
        .cfg_en   (cfg_en),
        .cfg_err  (cfg_err),
        .busy     (busy),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [14:0] d, input logic last);
        check("s_ready_pre", bus.s_ready, 1);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        tick();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic cfg_wr(input logic [1:0] ch, input logic [5:0] term, input logic [14:0] care,
                          input logic [14:0] val, input logic en);
        cfg_ch   = ch;
        cfg_term = term;
        cfg_care = care;
        cfg_val  = val;
        cfg_en   = en;
        cfg_we   = 1'b1;
        tick();
        cfg_we   = 1'b0;
    endtask

    // Called right after the s_last edge: DRAIN now, OUT one edge later
    task automatic finish_path(input string tag, input logic [3:0] mask, input logic [15:0] cnt);
        check({tag, ".drain_valid"}, bus.m_valid, 0);
        check({tag, ".drain_busy"}, busy, 1);
        check({tag, ".drain_ready"}, bus.s_ready, 0);
        tick();
        check({tag, ".valid"}, bus.m_valid, 1);
        check({tag, ".mask"}, bus.m_mask, mask);
        check({tag, ".count"}, bus.m_count, cnt);
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        check({tag, ".post_valid"}, bus.m_valid, 0);
        check({tag, ".post_busy"}, busy, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        cfg_we = 1'b0; cfg_en = 1'b0; cfg_ch = '0; cfg_term = '0; cfg_care = '0; cfg_val = '0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.m_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst.m_valid", bus.m_valid, 0);
        check("rst.m_mask", bus.m_mask, 0);
        check("rst.m_count", bus.m_count, 0);
        check("rst.busy", busy, 0);
        check("rst.cfg_err", cfg_err, 0);
        check("rst.s_ready", bus.s_ready, 1);

        cfg_wr(2'd0, 6'd0, 15'h7FFF, 15'h4ABC, 1'b1);
        check("wr0.cfg_err", cfg_err, 0);
        send(15'h0000, 1'b0);
        check("p1.busy", busy, 1);
        send(15'h4ABC, 1'b0);
        send(15'h1234, 1'b1);
        finish_path("p1", 4'b0001, 16'd3);

        for (int i = 1; i <= 5; i++) send(15'(i), i == 5);
        finish_path("p5", 4'b0000, 16'd5);

        send(15'h4ABC, 1'b1);
        check("hold.drain_valid", bus.m_valid, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("hold.s_ready", bus.s_ready, 0);
            check("hold.m_valid", bus.m_valid, 1);
            check("hold.m_mask", bus.m_mask, 4'b0001);
            check("hold.m_count", bus.m_count, 16'd1);
            tick();
        end
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        check("hold.idle", busy, 0);
        send(15'h4ABC, 1'b1);
        finish_path("after_hold", 4'b0001, 16'd1);

        send(15'h4ABC, 1'b0);
        cfg_wr(2'd0, 6'd0, 15'h7FFF, 15'h4ABC, 1'b0);
        check("busy_wr.cfg_err", cfg_err, 1);
        tick();
        check("busy_wr.cfg_err_clr", cfg_err, 0);
        send(15'h0000, 1'b1);
        finish_path("busy_wr", 4'b0001, 16'd2);
        send(15'h4ABC, 1'b1);
        finish_path("busy_wr_kept", 4'b0001, 16'd1);

        cfg_ch = 2'd2; cfg_term = 6'd5; cfg_care = 15'h0000; cfg_val = 15'h0000; cfg_en = 1'b1;
        cfg_we = 1'b1;
        bus.s_valid = 1'b1; bus.s_data = 15'h0000; bus.s_last = 1'b1;
        tick();
        cfg_we = 1'b0;
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
        check("same.cfg_err", cfg_err, 0);
        finish_path("same_pre", 4'b0000, 16'd1);
        send(15'h0000, 1'b1);
        finish_path("same_post", 4'b0100, 16'd1);

        cfg_wr(2'd1, 6'd63, 15'h000F, 15'h0005, 1'b1);
        cfg_wr(2'd3, 6'd10, 15'h4000, 15'h4000, 1'b1);
        send(15'h0005, 1'b0);
        send(15'h4000, 1'b1);
        finish_path("multi", 4'b1110, 16'd2);

        send(15'h4ABC, 1'b0);
        send(15'h0001, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst.m_valid", bus.m_valid, 0);
        check("midrst.busy", busy, 0);
        check("midrst.s_ready", bus.s_ready, 1);
        check("midrst.m_count", bus.m_count, 0);
        check("midrst.m_mask", bus.m_mask, 0);
        repeat (3) tick();
        check("midrst.no_result", bus.m_valid, 0);
        send(15'h4ABC, 1'b1);
        finish_path("midrst_next", 4'b0000, 16'd1);

`ifdef PRM_CHK_HITCNT_EN
        cfg_wr(2'd1, 6'd0, 15'h0000, 15'h0000, 1'b1);
        for (int i = 0; i < 300; i++) send(15'(i), i == 299);
        check("hits.drain_valid", bus.m_valid, 0);
        tick();
        check("hits.valid", bus.m_valid, 1);
        check("hits.ch1", bus.m_hits[15:8], 8'd255);
        check("hits.ch0", bus.m_hits[7:0], 8'd0);
        check("hits.count", bus.m_count, 16'd300);
        check("hits.mask", bus.m_mask, 4'b0010);
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        check("hits.clear", bus.m_hits, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/prm_edge_chk_engine.md
PRM_EDGE_CHK_ENGINE -- requirements
Module: prm_edge_chk_engine

Interface
REQ-001 Parameter: IN_W, 15, sample code width (joint-space voxel code bits A..O).
REQ-002 Parameter: NUM_CH, 4, independent edge channels evaluated per sample.
REQ-003 Parameter: NUM_TERMS, 64, programmable product terms per channel.
REQ-004 Port: clk  input  1  sole clock, rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: cfg_we  input  1  term write strobe.
REQ-007 Port: cfg_ch  input  $clog2(NUM_CH)  target channel.
REQ-008 Port: cfg_term  input  $clog2(NUM_TERMS)  target term index.
REQ-009 Port: cfg_care  input  IN_W  term care mask (1 = bit participates).
REQ-010 Port: cfg_val  input  IN_W  term required value on cared bits.
REQ-011 Port: cfg_en  input  1  term enable.
REQ-012 Port: cfg_err  output  1  one-cycle pulse: write rejected.
REQ-013 Port: s_valid / s_ready  input / output  1 / 1  sample handshake.
REQ-014 Port: s_data  input  IN_W  sample code; s_last  input  1  final sample of one edge path.
REQ-015 Port: m_valid / m_ready  output / input  1 / 1  result handshake.
REQ-016 Port: m_mask  output  NUM_CH  per-channel blocked flag for the completed path.
REQ-017 Port: m_count  output  16  samples in completed path, saturating at 0xFFFF.
REQ-018 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-019 Term t of channel c SHALL match when en[c][t] and ((s_data ^ val[c][t]) & care[c][t]) == 0; care == 0 with en SHALL match every sample.
REQ-020 Sample hit[c] SHALL be the OR of all term matches of channel c; no enabled term gives hit 0.
REQ-021 Transfer SHALL occur on s_valid & s_ready; stage 1 registers hit vector, stage 2 ORs it into accumulator acc[NUM_CH] and increments the count.
REQ-022 FSM states SHALL be IDLE, ACCUM, DRAIN, OUT; IDLE->ACCUM on first accepted sample; ACCUM->DRAIN on accepted s_last; DRAIN->OUT after one cycle; OUT->IDLE on m_valid & m_ready.
REQ-023 A single sample with s_last from IDLE SHALL go IDLE->DRAIN directly.
REQ-024 m_valid SHALL assert exactly 2 cycles after the accepting edge of the s_last sample and hold with m_mask/m_count stable until accepted.
REQ-025 s_ready SHALL be 1 in IDLE and ACCUM, 0 in DRAIN and OUT.
REQ-026 acc and count SHALL clear on the OUT->IDLE transition; the next path starts from zero.
REQ-027 cfg_we SHALL update the term only when busy == 0; otherwise the table is unchanged and cfg_err pulses the next cycle.
REQ-028 cfg_we and an accepted sample in the same IDLE cycle: write takes effect, sample is evaluated with the pre-write table, then busy rises.
REQ-029 m_count SHALL saturate at 0xFFFF; acc SHALL remain sticky-OR across saturation.

Reset
REQ-030 rst SHALL return the FSM to IDLE, clear acc and count, and clear all en bits; care/val storage need not reset.
REQ-031 After reset: m_valid=0, m_mask=0, m_count=0, busy=0, cfg_err=0, s_ready=1.
REQ-032 rst mid-path SHALL discard the partial path; no result is emitted for it.

Configuration
REQ-033 Macro PRM_CHK_HITCNT_EN defined: output m_hits (NUM_CH*8) gives per-channel count of hit samples in the path, saturating 255, valid with m_valid, cleared with acc.
REQ-034 PRM_CHK_HITCNT_EN undefined: m_hits port and counters absent; all other behaviour identical.

Structure
REQ-035 Package prm_chk_pkg SHALL hold the FSM state enum, default parameter values and the 16-bit count width constant.
REQ-036 Sub-module prm_term_match SHALL evaluate one channel's NUM_TERMS terms against a sample and return the OR-reduced hit.

Verification
REQ-037 Program ch0 term0 care=0x7FFF val=0x4ABC en=1; 3-sample path 0x0000,0x4ABC,0x1234(last) -> m_mask=0b0001, m_count=3.
REQ-038 Path with no enabled terms, 5 samples -> m_mask=0, m_count=5, m_valid 2 cycles after last.
REQ-039 Hold m_ready=0 for 10 cycles in OUT -> s_ready=0, outputs stable; m_ready=1 -> IDLE, next path accepted next cycle.
REQ-040 cfg_we during ACCUM -> cfg_err pulses once, subsequent path results unchanged by the write.
REQ-041 Assert rst after 2 samples of a path -> no m_valid; next 1-sample path returns m_count=1, m_mask=0 (all en cleared).
REQ-042 With PRM_CHK_HITCNT_EN, ch1 care=0 en=1, 300-sample path -> m_hits[15:8]=255, m_count=300.
